mux_lut_pipe: RTL

MUX_LUT_PIPE -- requirements
Module: mux_lut_pipe

---
 rtl/mux_lut_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/mux_lut_pipe.sv
// mux_lut_pipe: N-input, W-bit-wide programmable LUT with a two-stage
// valid/ready pipeline. Each result bit is the truth-table entry selected by
// the corresponding bit of every operand (operand 0 = index LSB).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   cfg_we, cfg_table    truth-table write strobe / new table (entry k = bit k)
//   table_o              currently active truth table
//   in_valid/in_ready    operand-set handshake; in_data holds op k at [k*W +: W]
//   out_valid/out_ready  result handshake; out_data is the W-bit result

// One bit lane: binary tree of 2:1 muxes, level l selected by sel[l],
// table entries as leaves.
module mux_lut_lane #(
  parameter int N = 2
) (
  input  logic [2**N-1:0] tbl,
  input  logic [N-1:0]    sel,
  output logic            y
);
  localparam int T = 2**N;

  logic [T-1:0] t;

  // Collapse pairs in place: after level l, entries [0 .. T>>(l+1)) hold
  // the surviving subtree values. Writes at j never clobber unread 2j/2j+1.
  always_comb begin
    t = tbl;
    for (int l = 0; l < N; l++) begin
      for (int j = 0; j < (T >> (l + 1)); j++) begin
        t[j] = sel[l] ? t[2*j+1] : t[2*j];
      end
    end
    y = t[0];
  end
endmodule

module mux_lut_pipe #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2**N-1:0]   cfg_table,
  output logic [2**N-1:0]   table_o,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data
);
  localparam int T = 2**N;
  // Power-up table is AND: only the all-ones index yields 1.
  localparam logic [T-1:0] RST_TBL = {1'b1, {(T-1){1'b0}}};

  logic [T-1:0]   tbl;
  logic           s1_valid, s2_valid;
  logic [N*W-1:0] s1_ops;
  logic [T-1:0]   s1_tbl;
  logic [W-1:0]   s2_data;
  logic           s2_adv, accept;

  logic [W-1:0][N-1:0] sel;
  logic [W-1:0]        res;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Bit i of every operand forms the select vector of lane i.
  for (genvar i = 0; i < W; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_sel
      assign sel[i][k] = s1_ops[k*W+i];
    end
    mux_lut_lane #(.N(N)) u_lane (
      .tbl (s1_tbl),
      .sel (sel[i]),
      .y   (res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl      <= RST_TBL;
      s1_valid <= 1'b0;
      s1_ops   <= '0;
      s1_tbl   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (cfg_we) tbl <= cfg_table;
      // S1 captures the pre-write table, so a set accepted on a cfg_we edge
      // still computes with the old table.
      if (in_ready) begin
        s1_valid <= in_valid;
        if (accept) begin
          s1_ops <= in_data;
          s1_tbl <= tbl;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= res;
      end
    end
  end

  assign table_o   = tbl;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
endmodule
